act_mem_mp: RTL
===============

Name: act_mem_mp

Overview:
Multi-channel successor to the access control table (ACT) memory. It holds DEPTH entries of entry_t and serves NUM_CH independent requesters (malloc, dealloc, checker, ...) through valid/ready handshakes with round-robin arbitration. It adds a hardware clear sweep after reset, plus an on-demand clear command that can target all entries or only the entries of one owner. It sits between the MPU allocation/check engines and the table storage.

Parameters:
DEPTH, BLOCK_COUNT, number of table entries (power of two, >=2)
NUM_CH, 2, number of requester channels (1..8)
AW, $clog2(DEPTH), entry address width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel grant/accept (one-hot or zero)
req_we  in  NUM_CH  per-channel 1=write, 0=read
req_addr  in  NUM_CH x AW  per-channel entry index (packed array)
req_wdata  in  NUM_CH x entry_t  per-channel write data (unpacked array)
rsp_valid  out  NUM_CH  one-hot response strobe
rsp_rdata  out  entry_t  shared response data
clr_req  in  1  clear command pulse
clr_owner_en  in  1  1=clear only entries owned by clr_owner; 0=clear all
clr_owner  in  owner width  owner id filter (width taken from the entry_t owner field)
clr_done  out  1  one-cycle pulse when a clear sweep finishes
bsy  out  1  table unavailable (INIT or SWEEP)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata='0, clr_done=0, bsy=1, state=INIT, idx=0, rr_ptr=0.
- States:
  - INIT: after reset. Writes '0 to mem[idx] each cycle and increments idx. When it writes idx==DEPTH-1, it moves to OP and bsy falls on the same edge. INIT therefore lasts exactly DEPTH cycles after rst drops.
  - OP: serves requests.
  - SWEEP: runs a clear command.
- req_ready is combinational. It is zero unless state==OP and no clr_req is present that cycle.
- Arbitration: search req_valid starting at rr_ptr, wrapping modulo NUM_CH. The first set bit gets req_ready. At most one grant per cycle.
- rr_ptr update: on a transfer (valid&ready) by channel i, rr_ptr <= (i+1) mod NUM_CH. Otherwise rr_ptr holds.
- Transfer rules: a requester holds valid, we, addr and wdata stable until ready. Deasserting valid before ready is allowed (the request is dropped).
- Read: rsp_valid[i]=1 exactly one cycle after the transfer edge. rsp_rdata = mem[addr] as it was at the transfer.
- Write: mem[addr] is updated at the transfer edge. rsp_valid[i] pulses one cycle later as an acknowledge, with rsp_rdata = the written data.
- Responses: rsp_valid is high for one cycle per transfer. rsp_rdata holds its value when rsp_valid=0.
- Back-to-back: a read of an address written in the previous cycle returns the new data.
- clr_req:
  - Sampled only in OP. It has priority over requests that cycle (no grant).
  - It latches clr_owner_en and clr_owner, sets idx=0, enters SWEEP and raises bsy on the next edge.
  - It is ignored in INIT or SWEEP.
- SWEEP: one entry per cycle, idx 0..DEPTH-1.
  - If the latched owner_en=0, write '0.
  - Otherwise write '0 only if mem[idx].valid && mem[idx].owner == latched owner; leave other entries unchanged.
  - After idx==DEPTH-1: return to OP, bsy=0, and clr_done=1 for one cycle, all on the same edge. A sweep takes DEPTH cycles.
- Reset mid-operation: rst in any state restarts INIT. Pending responses are discarded (rsp_valid=0) and no clr_done is issued.
- A response due in the cycle clr_req is accepted is still delivered.
- idx is AW+1 bits wide, so no wrap ambiguity at DEPTH-1.

Decomposition:
- Package mpu_common holds:
  - entry_t (valid, read_mask, write_mask, owner, reservation_id), BLOCK_COUNT and BLOCK_COUNT_BITS.
  - A new enum act_mp_state_t {ACT_INIT, ACT_OP, ACT_SWEEP}.
  - An owner_id_t typedef matching entry_t.owner, used for clr_owner.
- Sub-module rr_arbiter (param N): inputs req and ptr; outputs a one-hot grant and the grant index. Combinational, instantiated once.
- Storage and the state machine stay in act_mem_mp.

Test Plan:
- Reset init (DEPTH=16, NUM_CH=3): hold rst 2 cycles, release -> bsy=1 for exactly 16 cycles, req_ready stays 0 with req_valid=3'b111, then all 16 entries read back '0.
- Write/read latency: ch0 writes addr 5 with valid=1, owner=2, reservation_id=7 -> rsp_valid=3'b001 on the next cycle with echoed data. ch0 then reads addr 5 back-to-back -> the same data 1 cycle later.
- Round-robin: req_valid=3'b111 held for 6 cycles from rr_ptr=0 -> grant order ch0,ch1,ch2,ch0,ch1,ch2, with one rsp_valid bit per cycle matching, delayed by 1.
- Owner clear: entries 1,3,9 owner=2 and entry 4 owner=1 (all valid); clr_req with owner_en=1, owner=2 -> bsy=1 for 16 cycles, clr_done pulses once, entries 1,3,9 read '0, entry 4 intact.
- Clear priority: clr_req asserted in the same cycle as ch1 req_valid -> no grant, SWEEP begins; ch1 is granted in the first OP cycle after clr_done. clr_req during SWEEP -> ignored (exactly one clr_done).
- Reset mid-sweep: assert rst at sweep idx=6 -> no clr_done, INIT of 16 cycles, all entries '0 afterwards.

Source files
------------

// File: rtl/act_mem_mp_pkg.sv
// Shared MPU types for the multi-channel ACT memory.
// Contents: table geometry (BLOCK_COUNT), entry_t layout, owner_id_t,
// act_mp_state_t and the clear-sweep match helper.
package mpu_common;

  localparam int unsigned BLOCK_COUNT      = 16;
  localparam int unsigned BLOCK_COUNT_BITS = $clog2(BLOCK_COUNT);
  localparam int unsigned MASK_W           = 4;
  localparam int unsigned OWNER_W          = 4;
  localparam int unsigned RES_ID_W         = 8;

  typedef logic [OWNER_W-1:0] owner_id_t;

  typedef struct packed {
    logic                valid;
    logic [MASK_W-1:0]   read_mask;
    logic [MASK_W-1:0]   write_mask;
    owner_id_t           owner;
    logic [RES_ID_W-1:0] reservation_id;
  } entry_t;

  typedef enum logic [1:0] {
    ACT_INIT,
    ACT_OP,
    ACT_SWEEP
  } act_mp_state_t;

  // True when a sweep should zero this entry.
  function automatic logic clear_hit(entry_t e, logic owner_en, owner_id_t owner);
    return !owner_en || (e.valid && (e.owner == owner));
  endfunction

endpackage

// File: rtl/act_mem_mp_if.sv
// Request/response and clear-command bundle for act_mem_mp.
// master: requesters drive req_valid/req_we/req_addr/req_wdata and clr_*;
//         they observe req_ready, rsp_valid, rsp_rdata, clr_done, bsy.
// slave : the table, opposite directions.
interface act_mem_mp_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned AW     = 4
);
  import mpu_common::*;

  logic [NUM_CH-1:0]         req_valid;
  logic [NUM_CH-1:0]         req_ready;
  logic [NUM_CH-1:0]         req_we;
  logic [NUM_CH-1:0][AW-1:0] req_addr;
  entry_t                    req_wdata [NUM_CH];
  logic [NUM_CH-1:0]         rsp_valid;
  entry_t                    rsp_rdata;
  logic                      clr_req;
  logic                      clr_owner_en;
  owner_id_t                 clr_owner;
  logic                      clr_done;
  logic                      bsy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, clr_req, clr_owner_en, clr_owner,
    input  req_ready, rsp_valid, rsp_rdata, clr_done, bsy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, clr_req, clr_owner_en, clr_owner,
    output req_ready, rsp_valid, rsp_rdata, clr_done, bsy
  );

endinterface

// File: rtl/act_mem_mp_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (N requests), ptr (highest-priority index),
//        gnt (one-hot or zero), gnt_idx (index of the granted request).
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] cand;
  logic          found;

  // Walk from ptr, wrapping modulo N; the first set request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/act_mem_mp.sv
// Multi-channel access control table memory with clear sweeps.
// Ports: clk, rst (sync, active-high); bus (slave modport) carrying
//   per-channel valid/ready requests, one-hot responses with shared data,
//   clear command (clr_req/clr_owner_en/clr_owner), clr_done pulse, bsy.
// After reset the table is zeroed one entry per cycle (INIT); a clear
// command zeroes all entries or one owner's entries the same way (SWEEP).
module act_mem_mp
  import mpu_common::*;
#(
  parameter int unsigned DEPTH  = BLOCK_COUNT,
  parameter int unsigned NUM_CH = 2
) (
  input  logic        clk,
  input  logic        rst,
  act_mem_mp_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = AW + 1;
  localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);

  entry_t            mem [DEPTH];

  act_mp_state_t     state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              own_en_q, own_en_d;
  owner_id_t         own_q, own_d;

  logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
  entry_t            rsp_rdata_q, rsp_rdata_d;
  logic              clr_done_q, clr_done_d;
  logic              bsy_q;

  logic [NUM_CH-1:0] arb_req, gnt;
  logic [PW-1:0]     gnt_idx;
  logic              xfer;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  entry_t            mem_wdata;

  logic [AW-1:0]     idx_addr;
  entry_t            sweep_cur;

  assign idx_addr  = idx_q[AW-1:0];
  assign sweep_cur = mem[idx_addr];

  // Grants only in OP; a clear command or reset in the same cycle blocks them.
  assign arb_req = (state_q == ACT_OP && !bus.clr_req && !rst) ? bus.req_valid : '0;

  rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign xfer          = |gnt;
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.clr_done  = clr_done_q;
  assign bus.bsy       = bsy_q;

  // Next-state, memory write port and response staging.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    own_en_d    = own_en_q;
    own_d       = own_q;
    mem_we      = 1'b0;
    mem_waddr   = idx_addr;
    mem_wdata   = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    clr_done_d  = 1'b0;

    unique case (state_q)
      ACT_INIT: begin
        mem_we = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ACT_OP;
          idx_d   = '0;
        end
      end

      ACT_OP: begin
        if (bus.clr_req) begin
          state_d  = ACT_SWEEP;
          idx_d    = '0;
          own_en_d = bus.clr_owner_en;
          own_d    = bus.clr_owner;
        end else if (xfer) begin
          rsp_valid_d = gnt;
          rr_ptr_d    = (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
          if (bus.req_we[gnt_idx]) begin
            mem_we      = 1'b1;
            mem_waddr   = bus.req_addr[gnt_idx];
            mem_wdata   = bus.req_wdata[gnt_idx];
            rsp_rdata_d = bus.req_wdata[gnt_idx];
          end else begin
            // Old contents: the memory array updates on the same edge.
            rsp_rdata_d = mem[bus.req_addr[gnt_idx]];
          end
        end
      end

      ACT_SWEEP: begin
        mem_we = clear_hit(sweep_cur, own_en_q, own_q);
        idx_d  = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d    = ACT_OP;
          idx_d      = '0;
          clr_done_d = 1'b1;
        end
      end

      default: state_d = ACT_INIT;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACT_INIT;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      own_en_q    <= 1'b0;
      own_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      clr_done_q  <= 1'b0;
      bsy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      own_en_q    <= own_en_d;
      own_q       <= own_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      clr_done_q  <= clr_done_d;
      bsy_q       <= (state_d != ACT_OP);
    end
  end

  // Table storage; contents are established by the INIT pass, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule
